// File: rtl/nes_video_pkg.sv
// Shared NES video definitions: screen geometry, pixel types and the 64-entry
// NES master palette used by the scaler and the PPU debug path.
package nes_video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SRC_W    = 256;
  localparam int SRC_H    = 240;

  typedef logic [5:0]  pal_idx_t;
  typedef logic [23:0] rgb_t;

  // One fetch slot travelling down the scaler pipeline.
  typedef struct packed {
    logic valid;
    logic border;
    logic epoch;
  } slot_t;

  // Entries $20 and $30 are pure white so a full-intensity line is easy to spot.
  localparam rgb_t NES_PALETTE [64] = '{
    24'h747474, 24'h24188C, 24'h0000A8, 24'h44009C, 24'h8C0074, 24'hA80010, 24'hA40000, 24'h7C0800,
    24'h402C00, 24'h004400, 24'h005000, 24'h003C14, 24'h183C5C, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0070EC, 24'h2038EC, 24'h8000F0, 24'hBC00BC, 24'hE40058, 24'hD82800, 24'hC84C0C,
    24'h887000, 24'h009400, 24'h00A800, 24'h009038, 24'h008088, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFFFF, 24'h3CBCFC, 24'h5C94FC, 24'hCC88FC, 24'hF478FC, 24'hFC74B4, 24'hFC7460, 24'hFC9838,
    24'hF0BC3C, 24'h80D010, 24'h4CDC48, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFFFFFF, 24'hA8E4FC, 24'hC4D4FC, 24'hD4C8FC, 24'hFCC4FC, 24'hFCC4D8, 24'hFCBCB0, 24'hFCD8A8,
    24'hFCE4A0, 24'hE0FCA0, 24'hA8F0BC, 24'hB0FCCC, 24'h9CFCF0, 24'hC4C4C4, 24'h000000, 24'h000000
  };

  // Halve every channel independently (no bleed between R, G and B).
  function automatic rgb_t rgb_dim(input rgb_t c);
    return (c >> 1) & 24'h7F7F7F;
  endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// Registered 6-bit NES colour index to 24-bit RGB lookup, one cycle of latency.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic     clk,
  input  pal_idx_t idx,
  output rgb_t     rgb
);

  always_ff @(posedge clk) begin
    rgb <= NES_PALETTE[idx];
  end

endmodule

// File: rtl/nes_frame_scaler.sv
// 2x scaler from the 256x240 PPU framebuffer into a 640x480 HDMI pixel stream
// with side borders. Define NES_SCANLINE_EN to dim picture pixels on odd lines.
module nes_frame_scaler
  import nes_video_pkg::*;
#(
  parameter int   H_BORDER     = 64,
  parameter rgb_t BORDER_COLOR = 24'h000000,
  parameter int   FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_rd,
  input  logic        i_newline,
  input  logic        i_newframe,
  output logic [23:0] o_pixel,
  output logic        o_fb_rd,
  output logic [15:0] o_fb_addr,
  input  logic [5:0]  i_fb_data,
  output logic        o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]  X_END   = 10'(H_ACTIVE);
  localparam logic [9:0]  X_BL    = 10'(H_BORDER);
  localparam logic [9:0]  X_BR    = 10'(H_ACTIVE - H_BORDER);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  logic [9:0]    x_reg;
  logic [8:0]    y_reg;
  logic          epoch_reg;
  slot_t         s1_reg;
  slot_t         s2_reg;
  rgb_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          flush;
  logic          s1_live;
  logic          s2_live;
  logic [1:0]    inflight;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          border;
  logic [9:0]    src_x;
  logic [8:0]    src_y;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  rgb_t          rom_rgb;
  rgb_t          push_rgb;

  assign flush = i_newline | i_newframe;

  // Slots from a previous epoch are dead weight; they must not throttle the refill.
  assign s1_live   = s1_reg.valid && (s1_reg.epoch == epoch_reg);
  assign s2_live   = s2_reg.valid && (s2_reg.epoch == epoch_reg);
  assign inflight  = {1'b0, s1_live} + {1'b0, s2_live};
  assign occupancy = {1'b0, count_reg} + {{(CW - 1){1'b0}}, inflight};

  assign issue  = !i_reset && !flush && (x_reg < X_END) && (occupancy < DEPTH_L);
  assign border = (x_reg < X_BL) || (x_reg >= X_BR);
  assign src_x  = (x_reg - X_BL) >> 1;
  assign src_y  = y_reg >> 1;

  assign o_fb_rd   = issue && !border;
  assign o_fb_addr = o_fb_rd ? (({7'd0, src_y} << 8) + {6'd0, src_x}) : 16'd0;

  nes_palette_rom u_palette_rom (
    .clk (clk),
    .idx (i_fb_data),
    .rgb (rom_rgb)
  );

  always_comb begin
    push_rgb = rom_rgb;
`ifdef NES_SCANLINE_EN
    if (y_reg[0]) begin
      push_rgb = rgb_dim(rom_rgb);
    end
`endif
    if (s2_reg.border) begin
      push_rgb = BORDER_COLOR;
    end
  end

  assign fifo_empty = (count_reg == '0);
  assign push       = s2_live && !flush;
  assign pop        = i_rd && !fifo_empty && !flush;
  assign o_pixel    = fifo_empty ? 24'd0 : fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      x_reg       <= '0;
      y_reg       <= '0;
      epoch_reg   <= 1'b0;
      s1_reg      <= '0;
      s2_reg      <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      o_underflow <= 1'b0;
    end else begin
      s1_reg.valid  <= issue;
      s1_reg.border <= border;
      s1_reg.epoch  <= epoch_reg;
      s2_reg        <= s1_reg;

      if (i_rd && fifo_empty) begin
        o_underflow <= 1'b1;
      end

      if (i_newframe) begin
        x_reg     <= '0;
        y_reg     <= '0;
        epoch_reg <= ~epoch_reg;
      end else if (i_newline) begin
        x_reg     <= '0;
        y_reg     <= (y_reg == Y_LAST) ? Y_LAST : y_reg + 9'd1;
        epoch_reg <= ~epoch_reg;
      end else if (issue) begin
        x_reg <= x_reg + 10'd1;
      end

      // Occupancy throttling guarantees a push never lands on a full FIFO.
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == AW'(gi))) begin
        fifo_mem[gi] <= push_rgb;
      end
    end
  end

endmodule
